dlfloat_dot_engine: RTL and testbench
=====================================

// Module: dlfloat_dot_engine
// PURPOSE
// - Parametrised successor to the 2-cycle DLFloat16 MAC wrapper: computes a DLFloat16 dot product
//   sum(a[i]*b[i]), i=0..LEN-1, over a narrow serial bus with valid/ready handshakes on both sides.
// - Sits between the tt_um top-level pins and the DLFloat16 multiply/add datapaths.
// - Replaces the free-running load/emit toggles with explicit framing, back-pressure and
//   programmable vector length.
// PARAMETERS
// - BUS_W      8  operand/result bus width; legal values 4, 8, 16 (16 % BUS_W == 0)
// - LEN_W      8  width of cfg_len; max vector length 2**LEN_W-1
// PORTS
// - clk        in   1      single clock, rising edge
// - rst        in   1      synchronous, active-high reset
// - start      in   1      pulse in IDLE: sample cfg_len, clear accumulator, begin job
// - cfg_len    in   LEN_W  number of (a,b) pairs; 0 treated as 1
// - in_data    in   BUS_W  operand chunk, LS chunk first; a[i] fully, then b[i]
// - in_valid   in   1      in_data valid
// - in_ready   out  1      engine accepts chunk (transfer = in_valid & in_ready)
// - out_data   out  BUS_W  result chunk, LS chunk first
// - out_valid  out  1      out_data valid
// - out_ready  in   1      sink accepts chunk (transfer = out_valid & out_ready)
// - out_last   out  1      high with final result chunk
// - busy       out  1      high in every state except IDLE
// BEHAVIOUR
// - Format: {sign, exp[5:0] bias 31, mant[8:0]}, hidden 1. 0x0000 = zero. 0xFFFF = NaN, sticky.
// - Reset (rst=1 at clk edge, any state): FSM->IDLE; acc, count, chunk index cleared.
//   in_ready=0, out_valid=0, out_last=0, busy=0, out_data=0.
// - Reset mid-job aborts it; no partial result is emitted.
// - FSM IDLE: start=1 -> LOAD, latch len=max(cfg_len,1), acc<=0.
// - FSM LOAD: in_ready=1. Accept 32/BUS_W chunks into {b,a} shift reg; last chunk -> MUL.
//   in_valid=0 stalls with no state change.
// - FSM MUL: in_ready=0. prod_r <= a*b:
//   - mantissa 10x10 product, truncate, normalise by 1 on bit19; exp = ea+eb-31 (+1 if normalised)
//   - either operand 0 -> 0; either operand 0xFFFF -> 0xFFFF
//   - next state ACC
// - FSM ACC: acc <= acc + prod_r:
//   - align smaller-exp mantissa by right shift (truncate)
//   - add same sign, subtract opposite sign; renormalise
//   - 0 operand passes the other unchanged; exact cancellation -> 0x0000; 0xFFFF dominates
//   - count++; count==len -> EMIT, else LOAD
// - FSM EMIT: out_valid=1. out_data = acc chunk k, k=0..16/BUS_W-1; k advances only on transfer.
//   - out_ready=0 holds out_data/out_last stable
//   - out_last=1 on k=16/BUS_W-1; its transfer -> IDLE, busy=0 next cycle
// - start outside IDLE ignored; cfg_len changes after sampling ignored.
// - in_valid outside LOAD ignored (no chunk consumed).
// - Latency: last input chunk -> first out_valid = 2 cycles (MUL, ACC), for BUS_W=8/no stall;
//   pair throughput = 32/BUS_W+2 cycles.
// - Exponent arithmetic carried 8 bits signed internally; result handling per DLF_SAT_EN.
// CONFIGURATION
// - DLF_SAT_EN defined:
//   - exp>62 after MUL/ACC -> max finite {s,6'h3E,9'h1FF} (0x7DFF / 0xFDFF)
//   - exp<1 -> 0x0000
//   - 0xFFFF never produced by overflow
// - DLF_SAT_EN undefined: exponent kept modulo 64 (wraps), matching legacy MAC numerics.
// TESTING
// - T1 rst mid-LOAD (after 2 chunks): next cycle busy=0, in_ready=0, out_valid=0. New job then
//   runs clean.
// - T2 len=1, a=0x3E00 (1.0), b=0x4000 (2.0), BUS_W=8 -> out chunks 0x00, 0x40, out_last on 2nd.
// - T3 len=2, a={0x3E00,0x3E00}, b={0x4000,0x4000} -> 0x4200 (4.0).
//   Repeat with a[0]=0x3F00, b[0]=0x3F00 -> 1.5*1.5 product 0x4040.
// - T4 len=3, b[1]=0xFFFF -> result 0xFFFF. len=2, a={0x3E00,0xBE00}, b={0x3E00,0x3E00} -> 0x0000.
// - T5 back-pressure:
//   - in_valid random 50%; out_ready low 5 cycles during EMIT -> out_data stable, result unchanged
//   - start pulsed while busy -> ignored
// - T6 overflow, a=b=0x7C00 (exp 62), len=1:
//   - DLF_SAT_EN -> 0x7DFF
//   - without -> wrapped exp 29, result 0x3A00

Source files
------------

// File: rtl/dlfloat_dot_engine.sv
// dlfloat_dot_engine: serial-bus DLFloat16 dot product, sum of a[i]*b[i] over a programmable length.
// Define DLF_SAT_EN to saturate exponent overflow/underflow; otherwise exponents wrap modulo 64.
module dlfloat_dot_engine #(
    parameter int BUS_W = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [BUS_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [BUS_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);
    localparam int NCH  = 32 / BUS_W;
    localparam int NOUT = 16 / BUS_W;
    typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, EMIT} state_t;
    state_t           r_state;
    logic [31:0]      r_sh;
    logic [15:0]      r_prod, r_acc;
    logic [LEN_W-1:0] r_len, r_cnt;
    logic [3:0]       r_idx;

    function automatic logic [15:0] pack(input logic s, input logic signed [7:0] e, input logic [8:0] m);
`ifdef DLF_SAT_EN
        return (e > 8'sd62) ? {s, 6'h3E, 9'h1FF} : (e < 8'sd1) ? 16'h0000 : {s, 6'(e), m};
`else
        return {s, 6'(e), m};
`endif
    endfunction

    function automatic logic [3:0] lzc(input logic [9:0] v);
        lzc = 4'd0;
        for (int i = 0; i < 10; i++)
            if (v[i]) lzc = 4'(9 - i);
    endfunction

    logic [15:0]       w_a, w_b, w_prod;
    logic [9:0]        w_ma, w_mb;
    logic [19:0]       w_mp;
    logic [10:0]       w_mh;
    logic signed [7:0] w_pe;
    always_comb begin
        w_a    = r_sh[15:0];
        w_b    = r_sh[31:16];
        w_ma   = {1'b1, w_a[8:0]};
        w_mb   = {1'b1, w_b[8:0]};
        w_mp   = w_ma * w_mb;
        w_mh   = 11'(w_mp >> 9);
        w_pe   = 8'(w_a[14:9]) + 8'(w_b[14:9]) - 8'd31 + 8'(w_mh[10]);
        w_prod = (w_a == 16'hFFFF || w_b == 16'hFFFF) ? 16'hFFFF :
                 (w_a == 16'h0000 || w_b == 16'h0000) ? 16'h0000 :
                 pack(w_a[15] ^ w_b[15], w_pe, w_mh[10] ? w_mh[9:1] : w_mh[8:0]);
    end

    // Larger-magnitude operand sets sign and exponent; the other is aligned with truncation.
    logic              w_xbig, w_same;
    logic [15:0]       w_big, w_sml, w_sum;
    logic [9:0]        w_mbig, w_msml, w_d10;
    logic [10:0]       w_s11;
    logic [3:0]        w_lz;
    logic [8:0]        w_dm, w_sm;
    logic signed [7:0] w_se;
    always_comb begin
        w_xbig = r_acc[14:0] >= r_prod[14:0];
        w_big  = w_xbig ? r_acc : r_prod;
        w_sml  = w_xbig ? r_prod : r_acc;
        w_same = w_big[15] == w_sml[15];
        w_mbig = {1'b1, w_big[8:0]};
        w_msml = {1'b1, w_sml[8:0]} >> (w_big[14:9] - w_sml[14:9]);
        w_s11  = {1'b0, w_mbig} + {1'b0, w_msml};
        w_d10  = w_mbig - w_msml;
        w_lz   = lzc(w_d10);
        w_dm   = 9'(w_d10 << w_lz);
        w_se   = w_same ? 8'(w_big[14:9]) + 8'(w_s11[10]) : 8'(w_big[14:9]) - 8'(w_lz);
        w_sm   = w_same ? (w_s11[10] ? w_s11[9:1] : w_s11[8:0]) : w_dm;
        w_sum  = (r_acc == 16'hFFFF || r_prod == 16'hFFFF) ? 16'hFFFF :
                 (r_acc == 16'h0000) ? r_prod :
                 (r_prod == 16'h0000) ? r_acc :
                 (!w_same && w_d10 == 10'd0) ? 16'h0000 :
                 pack(w_big[15], w_se, w_sm);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sh      <= '0;
            r_prod    <= '0;
            r_acc     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_state  <= LOAD;
                    r_len    <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_idx    <= '0;
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
                end
                LOAD: if (in_valid) begin
                    r_sh  <= {in_data, r_sh[31:BUS_W]};
                    r_idx <= (r_idx == 4'(NCH - 1)) ? 4'd0 : r_idx + 4'd1;
                    if (r_idx == 4'(NCH - 1)) begin
                        r_state  <= MUL;
                        in_ready <= 1'b0;
                    end
                end
                MUL: begin
                    r_prod  <= w_prod;
                    r_state <= ACC;
                end
                ACC: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + LEN_W'(1);
                    if (r_cnt + LEN_W'(1) == r_len) begin
                        r_state   <= EMIT;
                        out_valid <= 1'b1;
                        out_data  <= BUS_W'(w_sum);
                        out_last  <= NOUT == 1;
                        r_idx     <= '0;
                    end else begin
                        r_state  <= LOAD;
                        in_ready <= 1'b1;
                    end
                end
                EMIT: if (out_ready) begin
                    if (out_last) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_data  <= '0;
                        busy      <= 1'b0;
                        r_idx     <= '0;
                    end else begin
                        r_idx    <= r_idx + 4'd1;
                        out_data <= BUS_W'(r_acc >> (BUS_W * (r_idx + 4'd1)));
                        out_last <= r_idx + 4'd2 == 4'(NOUT);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dlfloat_dot_engine.sv
// tb_dlfloat_dot_engine: randomized and directed checks of the dot engine against an arithmetic model.
module tb_dlfloat_dot_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cfg_len = '0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic       busy;
    int         n_err = 0;
    int         n_chk = 0;
    logic [15:0] ga [0:255];
    logic [15:0] gb [0:255];

    dlfloat_dot_engine #(.BUS_W(8), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pk(input bit s, input int e, input int m);
`ifdef DLF_SAT_EN
        if (e > 62) return s ? 16'hFDFF : 16'h7DFF;
        if (e < 1) return 16'h0000;
`endif
        return {s, 6'(e & 63), 9'(m & 511)};
    endfunction

    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        int p, e;
        if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
        if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
        p = (512 + int'(a[8:0])) * (512 + int'(b[8:0]));
        e = int'(a[14:9]) + int'(b[14:9]) - 31;
        if (p >= (1 << 19)) begin
            p = p / 1024;
            e++;
        end else p = p / 512;
        return pk(a[15] ^ b[15], e, p - 512);
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] x, input logic [15:0] y);
        int ex, ey, mx, my, e, v, m;
        if (x == 16'hFFFF || y == 16'hFFFF) return 16'hFFFF;
        if (x == 16'h0000) return y;
        if (y == 16'h0000) return x;
        ex = int'(x[14:9]);
        ey = int'(y[14:9]);
        mx = 512 + int'(x[8:0]);
        my = 512 + int'(y[8:0]);
        e = (ex > ey) ? ex : ey;
        mx = mx / (2 ** (e - ex));
        my = my / (2 ** (e - ey));
        v = (x[15] ? -mx : mx) + (y[15] ? -my : my);
        if (v == 0) return 16'h0000;
        m = (v < 0) ? -v : v;
        while (m >= 1024) begin
            m = m / 2;
            e++;
        end
        while (m < 512) begin
            m = m * 2;
            e--;
        end
        return pk(v < 0, e, m - 512);
    endfunction

    function automatic logic [15:0] dot(input int n);
        logic [15:0] acc = 16'h0000;
        for (int i = 0; i < n; i++) acc = fadd(acc, fmul(ga[i], gb[i]));
        return acc;
    endfunction

    function automatic logic [15:0] rnd_op();
        logic [5:0] e = 6'(24 + $urandom % 15);
        if ($urandom % 16 == 0) return 16'h0000;
        return {1'($urandom % 2), e, 9'($urandom % 512)};
    endfunction

    task automatic send_word(input logic [31:0] w, input bit rnd);
        bit done;
        int lim;
        for (int c = 0; c < 4; c++) begin
            done = 0;
            lim = 0;
            while (!done && lim < 100) begin
                in_data = w[8*c +: 8];
                in_valid = rnd ? 1'($urandom % 2) : 1'b1;
                done = in_valid && in_ready;
                @(posedge clk); #1;
                lim++;
            end
            if (!done) check("in_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input logic [15:0] exp, input int hold, input bit rnd,
                           output logic [15:0] res, output int lat);
        int k = 0;
        int lim = 0;
        res = '0;
        out_ready = 1'b0;
        while (!out_valid && lim < 50) begin
            @(posedge clk); #1;
            lim++;
        end
        lat = lim;
        if (!out_valid) check("out_timeout", 0, 1);
        start = hold > 0;
        cfg_len = 8'd5;
        for (int h = 0; h < hold; h++) begin
            check("hold_data", {24'd0, out_data}, {24'd0, exp[7:0]});
            check("hold_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        start = 1'b0;
        while (k < 2 && lim < 150) begin
            out_ready = rnd ? 1'($urandom % 2) : 1'b1;
            if (out_valid && out_ready) begin
                res[8*k +: 8] = out_data;
                check("out_last", out_last, k == 1);
                k++;
            end
            @(posedge clk); #1;
            lim++;
        end
        out_ready = 1'b0;
        if (k < 2) check("emit_timeout", 0, 1);
        check("busy_end", busy, 0);
    endtask

    task automatic run_job(input int n, input bit rnd, input int hold, output logic [15:0] res, output int lat);
        int m = (n == 0) ? 1 : n;
        start = 1'b1;
        cfg_len = 8'(n);
        @(posedge clk); #1;
        start = 1'b0;
        cfg_len = 8'($urandom);
        for (int i = 0; i < m; i++) begin
            start = rnd && i == 0;
            send_word({gb[i], ga[i]}, rnd);
            start = 1'b0;
        end
        collect(dot(m), hold, rnd, res, lat);
    endtask

    initial begin
        logic [15:0] res;
        int lat;
        int n;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", {24'd0, out_data}, 0);

        start = 1'b1;
        cfg_len = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("load_busy", busy, 1);
        check("load_in_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data = 8'h11;
        @(posedge clk); #1;
        in_data = 8'h22;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);

        ga[0] = 16'h3E00; gb[0] = 16'h4000;
        run_job(1, 0, 0, res, lat);
        check("t2_one_times_two", {16'd0, res}, 32'h4000);
        check("t2_latency", lat, 2);

        ga[1] = 16'h3E00; gb[1] = 16'h4000;
        run_job(2, 0, 0, res, lat);
        check("t3_sum_four", {16'd0, res}, 32'h4200);
        ga[0] = 16'h3F00; gb[0] = 16'h3F00;
        run_job(1, 0, 0, res, lat);
        check("t3_one_five_sq", {16'd0, res}, 32'h4040);
        run_job(2, 0, 0, res, lat);
        check("t3_mixed", {16'd0, res}, {16'd0, dot(2)});

        ga[0] = 16'h3E00; gb[0] = 16'h4000;
        ga[1] = 16'h3E00; gb[1] = 16'hFFFF;
        ga[2] = 16'h3E00; gb[2] = 16'h4000;
        run_job(3, 0, 0, res, lat);
        check("t4_nan", {16'd0, res}, 32'hFFFF);
        ga[0] = 16'h3E00; gb[0] = 16'h3E00;
        ga[1] = 16'hBE00; gb[1] = 16'h3E00;
        run_job(2, 0, 0, res, lat);
        check("t4_cancel", {16'd0, res}, 32'h0000);

        ga[0] = 16'h4100; gb[0] = 16'hC000;
        ga[1] = 16'h3E00; gb[1] = 16'h3E00;
        run_job(0, 0, 0, res, lat);
        check("len_zero_as_one", {16'd0, res}, {16'd0, fmul(16'h4100, 16'hC000)});

        ga[0] = 16'h7C00; gb[0] = 16'h7C00;
        run_job(1, 0, 3, res, lat);
`ifdef DLF_SAT_EN
        check("t6_overflow_sat", {16'd0, res}, 32'h7DFF);
`else
        check("t6_overflow_wrap", {16'd0, res}, 32'h3A00);
`endif

        for (int j = 0; j < 25; j++) begin
            n = 1 + $urandom % 8;
            for (int i = 0; i < n; i++) begin
                ga[i] = rnd_op();
                gb[i] = rnd_op();
            end
            run_job(n, 1, (j % 3 == 0) ? 5 : 0, res, lat);
            check("rand_dot", {16'd0, res}, {16'd0, dot(n)});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
